// File: rtl/video_timing_pkg.sv
// Shared raster-timing constants and helpers for the parallel RGB panel
// timing generator (default 480x272 panel).
package video_timing_pkg;

  localparam int CoordW = 10;

  localparam int DefHRes        = 480;
  localparam int DefHFrontPorch = 2;
  localparam int DefHSyncPulse  = 41;
  localparam int DefHBackPorch  = 2;

  localparam int DefVRes        = 272;
  localparam int DefVFrontPorch = 2;
  localparam int DefVSyncPulse  = 10;
  localparam int DefVBackPorch  = 2;

  function automatic int h_total(int hres, int hfp, int hsp, int hbp);
    return hres + hfp + hsp + hbp;
  endfunction

  function automatic int v_total(int vres, int vfp, int vsp, int vbp);
    return vres + vfp + vsp + vbp;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter plus its active-low sync pulse,
// registered from the next count so sync lines up with the presented count.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int Res        = DefHRes,
  parameter int FrontPorch = DefHFrontPorch,
  parameter int SyncPulse  = DefHSyncPulse,
  parameter int BackPorch  = DefHBackPorch
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  output logic [CoordW-1:0] count,
  output logic              wrap,
  output logic              sync_n
);

  localparam int Total = h_total(Res, FrontPorch, SyncPulse, BackPorch);

  localparam logic [CoordW-1:0] LastCnt   = CoordW'(Total - 1);
  localparam logic [CoordW-1:0] SyncFirst = CoordW'(Res + FrontPorch);
  localparam logic [CoordW-1:0] SyncLast  = CoordW'(Res + FrontPorch + SyncPulse - 1);

  logic [CoordW-1:0] r_count;
  logic              r_sync_n;
  logic [CoordW-1:0] w_next;
  logic              w_wrap;

  // Wrap is an explicit compare against the last position, never overflow.
  always_comb begin
    w_wrap = en && (r_count == LastCnt);
    w_next = r_count;
    if (en) begin
      w_next = w_wrap ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count  <= '0;
      r_sync_n <= 1'b1;
    end else begin
      r_count  <= w_next;
      r_sync_n <= !((w_next >= SyncFirst) && (w_next <= SyncLast));
    end
  end

  assign count  = r_count;
  assign wrap   = w_wrap;
  assign sync_n = r_sync_n;

endmodule

// File: rtl/video_signal_generator.sv
// Free-running raster timing generator: pixel coordinates sx/sy with
// active-low hsync/vsync, one pixel per clock, no gap cycles.
module video_signal_generator
  import video_timing_pkg::*;
#(
  parameter int HRes        = DefHRes,
  parameter int HFrontPorch = DefHFrontPorch,
  parameter int HSyncPulse  = DefHSyncPulse,
  parameter int HBackPorch  = DefHBackPorch,
  parameter int VRes        = DefVRes,
  parameter int VFrontPorch = DefVFrontPorch,
  parameter int VSyncPulse  = DefVSyncPulse,
  parameter int VBackPorch  = DefVBackPorch
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              hsync,
  output logic              vsync,
  output logic [CoordW-1:0] sx,
  output logic [CoordW-1:0] sy
);

  logic w_h_wrap;

  video_axis_counter #(
    .Res        (HRes),
    .FrontPorch (HFrontPorch),
    .SyncPulse  (HSyncPulse),
    .BackPorch  (HBackPorch)
  ) u_h_axis (
    .clk    (clk),
    .rstn   (rstn),
    .en     (1'b1),
    .count  (sx),
    .wrap   (w_h_wrap),
    .sync_n (hsync)
  );

  // The line counter advances only on the cycle the pixel counter wraps.
  video_axis_counter #(
    .Res        (VRes),
    .FrontPorch (VFrontPorch),
    .SyncPulse  (VSyncPulse),
    .BackPorch  (VBackPorch)
  ) u_v_axis (
    .clk    (clk),
    .rstn   (rstn),
    .en     (w_h_wrap),
    .count  (sy),
    .wrap   (),
    .sync_n (vsync)
  );

endmodule

// File: tb/tb_video_signal_generator.sv
// Directed bench for video_signal_generator: default panel line timing, a
// short-frame variant for frame timing, and a tiny 8x4 raster.
module tb_video_signal_generator;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       hs_d, vs_d, hs_m, vs_m, hs_s, vs_s;
  logic [9:0] sx_d, sy_d, sx_m, sy_m, sx_s, sy_s;

  int errors = 0;
  int checks = 0;

  // Default 480x272 panel.
  video_signal_generator u_dut (
    .clk(clk), .rstn(rstn), .hsync(hs_d), .vsync(vs_d), .sx(sx_d), .sy(sy_d)
  );

  // Default horizontal timing, 4-line frame: VTotal=8, vsync low on sy 5..6.
  video_signal_generator #(
    .VRes(4), .VFrontPorch(1), .VSyncPulse(2), .VBackPorch(1)
  ) u_mid (
    .clk(clk), .rstn(rstn), .hsync(hs_m), .vsync(vs_m), .sx(sx_m), .sy(sy_m)
  );

  // 8x4 raster: HTotal=12 (hsync low sx 9..10), VTotal=7 (vsync low sy 5).
  video_signal_generator #(
    .HRes(8), .HFrontPorch(1), .HSyncPulse(2), .HBackPorch(1),
    .VRes(4), .VFrontPorch(1), .VSyncPulse(1), .VBackPorch(1)
  ) u_small (
    .clk(clk), .rstn(rstn), .hsync(hs_s), .vsync(vs_s), .sx(sx_s), .sy(sy_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (sx_d !== 10'd0) begin errors++; $display("FAIL reset_sx: got %0d expected 0", sx_d); end
    checks++; if (sy_d !== 10'd0) begin errors++; $display("FAIL reset_sy: got %0d expected 0", sy_d); end
    checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hs_d); end
    checks++; if (vs_d !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vs_d); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++; if (sx_d !== 10'd1) begin errors++; $display("FAIL release_first_sx: got %0d expected 1", sx_d); end
    repeat (499) step();
    checks++; if (sx_d !== 10'd500) begin errors++; $display("FAIL midline_sx: got %0d expected 500", sx_d); end
    checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL midline_hsync: got %b expected 0", hs_d); end
    // Asynchronous assertion between clock edges, while hsync is low.
    #2 rstn = 1'b0;
    #1;
    checks++; if (sx_d !== 10'd0) begin errors++; $display("FAIL async_sx: got %0d expected 0", sx_d); end
    checks++; if (sy_d !== 10'd0) begin errors++; $display("FAIL async_sy: got %0d expected 0", sy_d); end
    checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL async_hsync: got %b expected 1", hs_d); end
    checks++; if (vs_d !== 1'b1) begin errors++; $display("FAIL async_vsync: got %b expected 1", vs_d); end
  endtask

  task automatic test_line();
    int   fall1 = -1;
    int   fall2 = -1;
    int   low   = 0;
    logic prev  = 1'b1;
    do_reset();
    for (int n = 1; n <= 1100; n++) begin
      int   esx;
      int   esy;
      logic ehs;
      step();
      esx = n % 525;
      esy = n / 525;
      ehs = !(esx >= 482 && esx <= 522);
      checks++; if (sx_d !== 10'(esx)) begin errors++; $display("FAIL line_sx n=%0d: got %0d expected %0d", n, sx_d, esx); end
      checks++; if (sy_d !== 10'(esy)) begin errors++; $display("FAIL line_sy n=%0d: got %0d expected %0d", n, sy_d, esy); end
      checks++; if (hs_d !== ehs) begin errors++; $display("FAIL line_hsync n=%0d sx=%0d: got %b expected %b", n, esx, hs_d, ehs); end
      if (n <= 525 && hs_d === 1'b0) low++;
      if (prev === 1'b1 && hs_d === 1'b0) begin
        if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
      end
      prev = hs_d;
    end
    checks++; if (low != 41) begin errors++; $display("FAIL hsync_width: got %0d expected 41", low); end
    checks++; if (fall1 != 482) begin errors++; $display("FAIL hsync_first_fall: got %0d expected 482", fall1); end
    checks++; if (fall2 - fall1 != 525) begin errors++; $display("FAIL hsync_period: got %0d expected 525", fall2 - fall1); end
  endtask

  task automatic test_frame();
    int   fall1 = -1;
    int   fall2 = -1;
    int   low   = 0;
    int   vis   = 0;
    logic prev  = 1'b1;
    do_reset();
    for (int n = 0; n <= 8500; n++) begin
      int   esx;
      int   esy;
      logic ehs;
      logic evs;
      if (n > 0) step(); else #1;
      esx = n % 525;
      esy = (n / 525) % 8;
      ehs = !(esx >= 482 && esx <= 522);
      evs = !(esy == 5 || esy == 6);
      checks++; if (sx_m !== 10'(esx)) begin errors++; $display("FAIL frame_sx n=%0d: got %0d expected %0d", n, sx_m, esx); end
      checks++; if (sy_m !== 10'(esy)) begin errors++; $display("FAIL frame_sy n=%0d: got %0d expected %0d", n, sy_m, esy); end
      checks++; if (hs_m !== ehs) begin errors++; $display("FAIL frame_hsync n=%0d: got %b expected %b", n, hs_m, ehs); end
      checks++; if (vs_m !== evs) begin errors++; $display("FAIL frame_vsync n=%0d sy=%0d: got %b expected %b", n, esy, vs_m, evs); end
      if (n < 4200) begin
        if (vs_m === 1'b0) low++;
        if (sx_m < 10'd480 && sy_m < 10'd4) vis++;
      end
      if (prev === 1'b1 && vs_m === 1'b0) begin
        if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
      end
      prev = vs_m;
    end
    checks++; if (vis != 1920) begin errors++; $display("FAIL frame_visible: got %0d expected 1920", vis); end
    checks++; if (low != 1050) begin errors++; $display("FAIL vsync_width: got %0d expected 1050", low); end
    checks++; if (fall1 != 2625) begin errors++; $display("FAIL vsync_first_fall: got %0d expected 2625", fall1); end
    checks++; if (fall2 - fall1 != 4200) begin errors++; $display("FAIL vsync_period: got %0d expected 4200", fall2 - fall1); end
  endtask

  task automatic test_small();
    int   hf1 = -1;
    int   hf2 = -1;
    int   vf1 = -1;
    int   vf2 = -1;
    int   low = 0;
    int   vis = 0;
    logic hp  = 1'b1;
    logic vp  = 1'b1;
    do_reset();
    for (int n = 0; n <= 200; n++) begin
      int   esx;
      int   esy;
      logic ehs;
      logic evs;
      if (n > 0) step(); else #1;
      esx = n % 12;
      esy = (n / 12) % 7;
      ehs = !(esx == 9 || esx == 10);
      evs = !(esy == 5);
      checks++; if (sx_s !== 10'(esx)) begin errors++; $display("FAIL small_sx n=%0d: got %0d expected %0d", n, sx_s, esx); end
      checks++; if (sy_s !== 10'(esy)) begin errors++; $display("FAIL small_sy n=%0d: got %0d expected %0d", n, sy_s, esy); end
      checks++; if (hs_s !== ehs) begin errors++; $display("FAIL small_hsync n=%0d: got %b expected %b", n, hs_s, ehs); end
      checks++; if (vs_s !== evs) begin errors++; $display("FAIL small_vsync n=%0d: got %b expected %b", n, vs_s, evs); end
      if (n < 84) begin
        if (vs_s === 1'b0) low++;
        if (sx_s < 10'd8 && sy_s < 10'd4) vis++;
      end
      if (hp === 1'b1 && hs_s === 1'b0) begin
        if (hf1 < 0) hf1 = n; else if (hf2 < 0) hf2 = n;
      end
      if (vp === 1'b1 && vs_s === 1'b0) begin
        if (vf1 < 0) vf1 = n; else if (vf2 < 0) vf2 = n;
      end
      hp = hs_s;
      vp = vs_s;
    end
    checks++; if (vis != 32) begin errors++; $display("FAIL small_visible: got %0d expected 32", vis); end
    checks++; if (low != 12) begin errors++; $display("FAIL small_vsync_width: got %0d expected 12", low); end
    checks++; if (hf1 != 9) begin errors++; $display("FAIL small_hsync_first_fall: got %0d expected 9", hf1); end
    checks++; if (hf2 - hf1 != 12) begin errors++; $display("FAIL small_hsync_period: got %0d expected 12", hf2 - hf1); end
    checks++; if (vf1 != 60) begin errors++; $display("FAIL small_vsync_first_fall: got %0d expected 60", vf1); end
    checks++; if (vf2 - vf1 != 84) begin errors++; $display("FAIL small_vsync_period: got %0d expected 84", vf2 - vf1); end
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
